// File: rtl/lfu_cache_tracker.sv
// rtl/lfu_cache_tracker.sv - LFU occupancy tracker with sequential min-scan eviction
module lfu_cache_tracker #(
  parameter int NUM_SLOTS = 4,
  parameter int CAPACITY  = 4,
  parameter int CNT_W     = 8,
  parameter int AGING     = 1,
  parameter int ID_W      = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ID_W-1:0]      req_id,
  output logic                 resp_valid,
  output logic                 resp_hit,
  output logic                 evict_valid,
  output logic [ID_W-1:0]      evict_id,
  output logic [NUM_SLOTS-1:0] resident,
  input  logic [ID_W-1:0]      dbg_sel,
  output logic [CNT_W-1:0]     dbg_count
);
  localparam int               ID_SPAN  = 1 << ID_W;
  localparam int               OCC_W    = $clog2(NUM_SLOTS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  // (max >> 1) + 1 is exactly the top bit of the counter
  localparam logic [CNT_W-1:0] CNT_AGED = CNT_W'(1) << (CNT_W - 1);
  localparam logic [OCC_W-1:0] OCC_CAP  = OCC_W'(CAPACITY);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_SLOTS - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, SCAN, EVICT} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0]   count [NUM_SLOTS];
  logic [OCC_W-1:0]   occupancy;
  logic [ID_W-1:0]    cur_id, scan_idx, min_id;
  logic [CNT_W-1:0]   min_val;
  logic [ID_SPAN-1:0] id_ok, res_pad;
  logic [CNT_W-1:0]   cnt_pad [ID_SPAN];
  logic               hit_sat;

  // Widen slot state to the full id space; ids past NUM_SLOTS read as invalid/zero
  for (genvar g = 0; g < ID_SPAN; g++) begin : g_pad
    if (g < NUM_SLOTS) begin : g_real
      assign id_ok[g]   = 1'b1;
      assign res_pad[g] = resident[g];
      assign cnt_pad[g] = count[g];
    end else begin : g_void
      assign id_ok[g]   = 1'b0;
      assign res_pad[g] = 1'b0;
      assign cnt_pad[g] = '0;
    end
  end

  assign req_ready = (state == IDLE);
  assign dbg_count = cnt_pad[dbg_sel];
  assign hit_sat   = (cnt_pad[cur_id] == CNT_MAX);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state: out-of-range ids are accepted but never leave IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid && id_ok[req_id]) state_nxt = ACCESS;
      ACCESS:  state_nxt = (!res_pad[cur_id] && occupancy >= OCC_CAP) ? SCAN : IDLE;
      SCAN:    if (scan_idx == LAST_ID) state_nxt = EVICT;
      EVICT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counters, residency, min-scan and registered response pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) count[i] <= '0;
      resident    <= '0;
      occupancy   <= '0;
      cur_id      <= '0;
      scan_idx    <= '0;
      min_id      <= '0;
      min_val     <= '0;
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      evict_valid <= 1'b0;
      evict_id    <= '0;
    end else begin
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      evict_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) cur_id <= req_id;
        ACCESS: begin
          if (res_pad[cur_id]) begin
            resp_valid <= 1'b1;
            resp_hit   <= 1'b1;
            for (int i = 0; i < NUM_SLOTS; i++) begin
              if (cur_id == ID_W'(i)) begin
                if (!hit_sat)         count[i] <= count[i] + 1'b1;
                else if (AGING != 0)  count[i] <= CNT_AGED;
              end else if (hit_sat && AGING != 0) begin
                count[i] <= count[i] >> 1;
              end
            end
          end else if (occupancy < OCC_CAP) begin
            resp_valid <= 1'b1;
            occupancy  <= occupancy + 1'b1;
            for (int i = 0; i < NUM_SLOTS; i++) begin
              if (cur_id == ID_W'(i)) begin
                resident[i] <= 1'b1;
                count[i]    <= CNT_W'(1);
              end
            end
          end else begin
            scan_idx <= '0;
            min_val  <= '1;
            min_id   <= '0;
          end
        end
        SCAN: begin
          // Strict compare keeps the lowest index on ties
          if (res_pad[scan_idx] && cnt_pad[scan_idx] < min_val) begin
            min_val <= cnt_pad[scan_idx];
            min_id  <= scan_idx;
          end
          scan_idx <= scan_idx + 1'b1;
        end
        EVICT: begin
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (min_id == ID_W'(i)) begin
              resident[i] <= 1'b0;
              count[i]    <= '0;
            end else if (cur_id == ID_W'(i)) begin
              resident[i] <= 1'b1;
              count[i]    <= CNT_W'(1);
            end
          end
          resp_valid  <= 1'b1;
          evict_valid <= 1'b1;
          evict_id    <= min_id;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lfu_cache_tracker.sv
// tb/tb_lfu_cache_tracker.sv - directed table-driven bench for lfu_cache_tracker
module tb_lfu_cache_tracker;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // dut_a: 4 slots, capacity 3, 8-bit counters
  logic       a_valid, a_ready, a_rv, a_rh, a_ev;
  logic [1:0] a_id, a_eid, a_sel;
  logic [3:0] a_res;
  logic [7:0] a_cnt;

  // dut_b (aging) and dut_c (saturate): 6 slots, 2-bit counters, shared inputs
  logic       b_valid;
  logic [2:0] b_id, b_sel;
  logic       b_ready, b_rv, b_rh, b_ev, c_ready, c_rv, c_rh, c_ev;
  logic [2:0] b_eid, c_eid;
  logic [5:0] b_res, c_res;
  logic [1:0] b_cnt, c_cnt;

  lfu_cache_tracker #(.NUM_SLOTS(4), .CAPACITY(3), .CNT_W(8), .AGING(1)) dut_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_id(a_id),
    .resp_valid(a_rv), .resp_hit(a_rh), .evict_valid(a_ev), .evict_id(a_eid),
    .resident(a_res), .dbg_sel(a_sel), .dbg_count(a_cnt));

  lfu_cache_tracker #(.NUM_SLOTS(6), .CAPACITY(6), .CNT_W(2), .AGING(1)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_id(b_id),
    .resp_valid(b_rv), .resp_hit(b_rh), .evict_valid(b_ev), .evict_id(b_eid),
    .resident(b_res), .dbg_sel(b_sel), .dbg_count(b_cnt));

  lfu_cache_tracker #(.NUM_SLOTS(6), .CAPACITY(6), .CNT_W(2), .AGING(0)) dut_c (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(c_ready), .req_id(b_id),
    .resp_valid(c_rv), .resp_hit(c_rh), .evict_valid(c_ev), .evict_id(c_eid),
    .resident(c_res), .dbg_sel(b_sel), .dbg_count(c_cnt));

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0] id;
    logic       hit;
    int         lat;
    logic       ev;
    logic [1:0] eid;
    logic [3:0] res;
    logic [7:0] cnt;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request to dut_a; lat = edges from the accepting edge to resp_valid
  task automatic a_req(input logic [1:0] id, output int lat, output logic hit,
                       output logic ev, output logic [1:0] eid);
    int k;
    k = 0;
    a_valid = 1'b1;
    a_id    = id;
    while (!a_ready && k < 20) begin tick(); k++; end
    chk("a_accept_ready", {31'd0, a_ready}, 1);
    tick();
    a_valid = 1'b0;
    lat = 0;
    while (!a_rv && lat < 20) begin tick(); lat++; end
    hit = a_rh;
    ev  = a_ev;
    eid = a_eid;
  endtask

  task automatic b_req(input logic [2:0] id, output int lat);
    int k;
    k = 0;
    b_valid = 1'b1;
    b_id    = id;
    while (!b_ready && k < 20) begin tick(); k++; end
    chk("b_accept_ready", {31'd0, b_ready}, 1);
    tick();
    b_valid = 1'b0;
    lat = 0;
    while (!b_rv && lat < 20) begin tick(); lat++; end
    chk("c_resp_sync", {31'd0, c_rv}, 1);
  endtask

  task automatic a_count(input logic [1:0] sel, input logic [7:0] exp, input string name);
    a_sel = sel;
    #1;
    chk(name, {24'd0, a_cnt}, {24'd0, exp});
  endtask

  initial begin
    int lat;
    int pulses;
    logic hit, ev;
    logic [1:0] eid;

    tbl[0] = '{2'd2, 1'b0, 1, 1'b0, 2'd0, 4'b0100, 8'd1};
    tbl[1] = '{2'd2, 1'b1, 1, 1'b0, 2'd0, 4'b0100, 8'd2};
    tbl[2] = '{2'd2, 1'b1, 1, 1'b0, 2'd0, 4'b0100, 8'd3};
    tbl[3] = '{2'd2, 1'b1, 1, 1'b0, 2'd0, 4'b0100, 8'd4};
    tbl[4] = '{2'd0, 1'b0, 1, 1'b0, 2'd0, 4'b0101, 8'd1};
    tbl[5] = '{2'd1, 1'b0, 1, 1'b0, 2'd0, 4'b0111, 8'd1};
    tbl[6] = '{2'd3, 1'b0, 6, 1'b1, 2'd0, 4'b1110, 8'd1};
    tbl[7] = '{2'd1, 1'b1, 1, 1'b0, 2'd0, 4'b1110, 8'd2};
    tbl[8] = '{2'd0, 1'b0, 6, 1'b1, 2'd3, 4'b0111, 8'd1};

    a_valid = 1'b0; a_id = '0; a_sel = '0;
    b_valid = 1'b0; b_id = '0; b_sel = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    tick();

    chk("rst_ready", {31'd0, a_ready}, 1);
    chk("rst_resident", {28'd0, a_res}, 0);
    chk("rst_resp_valid", {31'd0, a_rv}, 0);
    chk("rst_resp_hit", {31'd0, a_rh}, 0);
    chk("rst_evict_valid", {31'd0, a_ev}, 0);
    chk("rst_evict_id", {30'd0, a_eid}, 0);
    for (int i = 0; i < 4; i++) a_count(2'(i), 8'd0, "rst_count");

    // Aging vs saturation: build counts {3,2} then hit the saturated slot 0
    repeat (3) b_req(3'd0, lat);
    repeat (2) b_req(3'd1, lat);
    b_req(3'd0, lat);
    chk("age_lat", lat, 1);
    chk("age_hit", {31'd0, b_rh}, 1);
    b_sel = 3'd0; #1;
    chk("age_b_cnt0", {30'd0, b_cnt}, 2);
    chk("sat_c_cnt0", {30'd0, c_cnt}, 3);
    b_sel = 3'd1; #1;
    chk("age_b_cnt1", {30'd0, b_cnt}, 1);
    chk("sat_c_cnt1", {30'd0, c_cnt}, 2);
    b_req(3'd0, lat);
    b_sel = 3'd0; #1;
    chk("age_b_cnt0_again", {30'd0, b_cnt}, 3);
    chk("sat_c_cnt0_again", {30'd0, c_cnt}, 3);
    b_sel = 3'd6; #1;
    chk("dbg_out_of_range", {30'd0, b_cnt}, 0);

    // Out-of-range id is swallowed; a valid id on the next edge is taken normally
    b_valid = 1'b1; b_id = 3'd6;
    tick();
    chk("oor_ready_kept", {31'd0, b_ready}, 1);
    chk("oor_no_resp", {31'd0, b_rv}, 0);
    b_id = 3'd2;
    tick();
    chk("oor_next_accepted", {31'd0, b_ready}, 0);
    b_valid = 1'b0;
    tick();
    chk("oor_next_resp", {31'd0, b_rv}, 1);
    chk("oor_next_miss", {31'd0, b_rh}, 0);
    chk("oor_next_resident", {26'd0, b_res}, 6'b000111);

    // Table: hits, fills, evictions with tie to lowest index
    for (int r = 0; r < 9; r++) begin
      a_req(tbl[r].id, lat, hit, ev, eid);
      chk($sformatf("row%0d_hit", r), {31'd0, hit}, {31'd0, tbl[r].hit});
      chk($sformatf("row%0d_lat", r), lat, tbl[r].lat);
      chk($sformatf("row%0d_evict", r), {31'd0, ev}, {31'd0, tbl[r].ev});
      if (tbl[r].ev) chk($sformatf("row%0d_evict_id", r), {30'd0, eid}, {30'd0, tbl[r].eid});
      chk($sformatf("row%0d_resident", r), {28'd0, a_res}, {28'd0, tbl[r].res});
      a_count(tbl[r].id, tbl[r].cnt, $sformatf("row%0d_count", r));
    end

    // Fresh start: counts 3,1,1 then id 3 evicts id 1 (tie with id 2)
    rst = 1'b0; #2; rst = 1'b1;
    tick();
    repeat (3) a_req(2'd0, lat, hit, ev, eid);
    a_req(2'd1, lat, hit, ev, eid);
    a_req(2'd2, lat, hit, ev, eid);
    a_req(2'd3, lat, hit, ev, eid);
    chk("tie_lat", lat, 6);
    chk("tie_evict", {31'd0, ev}, 1);
    chk("tie_evict_id", {30'd0, eid}, 1);
    chk("tie_resident", {28'd0, a_res}, 4'b1101);
    a_count(2'd3, 8'd1, "tie_cnt3");
    a_count(2'd1, 8'd0, "tie_cnt1");
    a_count(2'd0, 8'd3, "tie_cnt0");

    // Reset during SCAN aborts with no pulse afterwards
    a_valid = 1'b1; a_id = 2'd1;
    chk("scan_pre_ready", {31'd0, a_ready}, 1);
    tick();
    a_valid = 1'b0;
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, a_ready}, 1);
    chk("midrst_resident", {28'd0, a_res}, 0);
    chk("midrst_resp", {31'd0, a_rv}, 0);
    for (int i = 0; i < 4; i++) a_count(2'(i), 8'd0, "midrst_count");
    @(negedge clk) rst = 1'b1;
    pulses = 0;
    repeat (12) begin
      tick();
      if (a_rv || a_ev) pulses++;
    end
    chk("midrst_no_pulse", pulses, 0);
    chk("midrst_ready_after", {31'd0, a_ready}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
